// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared types and constants for the multi-cycle RV32 control FSM.
//   alu_op_e  - ALU operation select driven to the datapath
//   state_e   - controller FSM states
//   OPC_*     - supported major opcodes (R, I-alu, load, store)
package ctrl_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_e;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXECUTE,
        MEM,
        WB,
        HALT
    } state_e;

    localparam logic [6:0] OPC_R     = 7'b0110011;
    localparam logic [6:0] OPC_IALU  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    // func7 pattern that turns add into sub and srl into sra
    localparam logic [6:0] FUNC7_ALT = 7'b0100000;

    function automatic logic opcode_supported(input logic [6:0] opcode);
        return (opcode == OPC_R) || (opcode == OPC_IALU) ||
               (opcode == OPC_LOAD) || (opcode == OPC_STORE);
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// multicycle_controller_if: instruction/data memory handshake bundle.
//   imem_req/imem_ack/imem_rdata - instruction fetch handshake
//   dmem_req/dmem_ack            - data access handshake
//   dmem_read_en/dmem_write_en   - access direction (load / store)
// master = controller side, slave = memory side.
interface multicycle_controller_if #(
    parameter int INSTR_WIDTH = 32
) ();
    logic [INSTR_WIDTH-1:0] imem_rdata;
    logic                   imem_req;
    logic                   imem_ack;
    logic                   dmem_req;
    logic                   dmem_ack;
    logic                   dmem_read_en;
    logic                   dmem_write_en;

    modport master (
        output imem_req, dmem_req, dmem_read_en, dmem_write_en,
        input  imem_rdata, imem_ack, dmem_ack
    );

    modport slave (
        input  imem_req, dmem_req, dmem_read_en, dmem_write_en,
        output imem_rdata, imem_ack, dmem_ack
    );
endinterface

// File: rtl/alu_decoder.sv
// alu_decoder: combinational opcode/func3/func7 -> ALU operation.
//   opcode (7) - instruction major opcode
//   func3  (3) - instruction func3 field
//   func7  (7) - instruction func7 field (imm[11:5] for I-alu)
//   alu_op     - decoded operation; add for loads, stores and unknown opcodes
module alu_decoder
    import ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] func3,
    input  logic [6:0] func7,
    output alu_op_e    alu_op
);

    logic is_r;

    assign is_r = (opcode == OPC_R);

    always_comb begin
        alu_op = ALU_ADD;
        if (is_r || (opcode == OPC_IALU)) begin
            case (func3)
                // there is no subi: the I-alu func7 bits are immediate data here
                3'b000: alu_op = (is_r && (func7 == FUNC7_ALT)) ? ALU_SUB : ALU_ADD;
                3'b001: alu_op = ALU_SLL;
                3'b010: alu_op = ALU_SLT;
                3'b011: alu_op = ALU_SLTU;
                3'b100: alu_op = ALU_XOR;
                // srli/srai share func3 with srl/sra and are split by func7
                3'b101: alu_op = (func7 == FUNC7_ALT) ? ALU_SRA : ALU_SRL;
                3'b110: alu_op = ALU_OR;
                3'b111: alu_op = ALU_AND;
                default: alu_op = ALU_ADD;
            endcase
        end
    end

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: multi-cycle RV32 control FSM
// (FETCH -> DECODE -> EXECUTE -> [MEM] -> [WB]).
//   clk, rst_n            - clock (rising edge), async active-low reset
//   mem (master)          - imem/dmem request/ack handshakes, dmem direction
//   alu_op                - ALU operation, valid from EXECUTE to end of MEM/WB
//   sel_bw_imm_rs2        - 1 = immediate operand, 0 = rs2
//   wr_back_sel           - 0 = memory data, 1 = ALU result
//   regfile_write_enable  - register write strobe (suppressed for rd = x0)
//   pc_write              - PC <= PC+4 strobe
//   illegal_instr         - one-cycle pulse on an unsupported opcode
//   instret               - retired-instruction counter (wraps)
//   mem_timeout           - sticky memory timeout flag
// Optional feature macro: MULTICYCLE_CTRL_TIMEOUT_EN (memory wait timeout
// with a HALT state). Without it mem_timeout is 0 and waits are unbounded.
module multicycle_controller
    import ctrl_pkg::*;
#(
    parameter int INSTR_WIDTH    = 32,
    parameter int ALU_OP_WIDTH   = 4,
    parameter int CNT_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    multicycle_controller_if.master  mem,
    output logic [ALU_OP_WIDTH-1:0]  alu_op,
    output logic                     sel_bw_imm_rs2,
    output logic                     wr_back_sel,
    output logic                     regfile_write_enable,
    output logic                     pc_write,
    output logic                     illegal_instr,
    output logic [CNT_WIDTH-1:0]     instret,
    output logic                     mem_timeout
);

    state_e                 state;
    state_e                 state_next;
    logic [INSTR_WIDTH-1:0] ir;
    logic [CNT_WIDTH-1:0]   instret_q;

    logic [6:0] opcode;
    logic [2:0] func3;
    logic [6:0] func7;
    logic [4:0] rd;
    logic       is_load;
    logic       is_store;
    logic       uses_imm;
    alu_op_e    dec_op;

    logic       imem_req_c;
    logic       dmem_req_c;
    logic       dmem_read_c;
    logic       dmem_write_c;
    alu_op_e    alu_op_c;
    logic       retire;
    logic       timeout_hit;

    assign opcode   = ir[6:0];
    assign rd       = ir[11:7];
    assign func3    = ir[14:12];
    assign func7    = ir[31:25];
    assign is_load  = (opcode == OPC_LOAD);
    assign is_store = (opcode == OPC_STORE);
    assign uses_imm = (opcode == OPC_IALU) || is_load || is_store;

    // Operand/immediate fields are consumed by the datapath, not the controller.
    logic unused_ir_fields;
    assign unused_ir_fields = ^ir[24:15];

    alu_decoder u_alu_decoder (
        .opcode (opcode),
        .func3  (func3),
        .func7  (func7),
        .alu_op (dec_op)
    );

`ifdef MULTICYCLE_CTRL_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WAIT_W-1:0] wait_cnt;
    logic              waiting;
    logic              timeout_q;

    // Derived from state rather than the request outputs to keep the
    // next-state logic free of a combinational loop.
    assign waiting     = ((state == FETCH) && !mem.imem_ack) ||
                         ((state == MEM)   && !mem.dmem_ack);
    assign timeout_hit = waiting && (wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            // any state change is an entry into a new wait window
            if (state_next != state) begin
                wait_cnt <= '0;
            end else if (waiting) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (timeout_hit) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign mem_timeout = timeout_q;
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

    assign timeout_hit = 1'b0;
    assign mem_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FETCH;
            ir        <= '0;
            instret_q <= '0;
        end else begin
            state <= state_next;
            if ((state == FETCH) && mem.imem_ack) begin
                ir <= mem.imem_rdata;
            end
            if (retire) begin
                instret_q <= instret_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_next           = state;
        imem_req_c           = 1'b0;
        dmem_req_c           = 1'b0;
        dmem_read_c          = 1'b0;
        dmem_write_c         = 1'b0;
        alu_op_c             = ALU_ADD;
        sel_bw_imm_rs2       = 1'b0;
        wr_back_sel          = 1'b1;
        regfile_write_enable = 1'b0;
        pc_write             = 1'b0;
        illegal_instr        = 1'b0;
        retire               = 1'b0;

        case (state)
            FETCH: begin
                imem_req_c = 1'b1;
                if (mem.imem_ack) begin
                    state_next = DECODE;
                end
            end
            DECODE: begin
                if (!opcode_supported(opcode)) begin
                    // skip the instruction without retiring it
                    illegal_instr = 1'b1;
                    pc_write      = 1'b1;
                    state_next    = FETCH;
                end else begin
                    state_next = EXECUTE;
                end
            end
            EXECUTE: begin
                alu_op_c       = dec_op;
                sel_bw_imm_rs2 = uses_imm;
                state_next     = (is_load || is_store) ? MEM : WB;
            end
            MEM: begin
                alu_op_c       = dec_op;
                sel_bw_imm_rs2 = 1'b1;
                dmem_req_c     = 1'b1;
                dmem_read_c    = is_load;
                dmem_write_c   = is_store;
                if (mem.dmem_ack) begin
                    if (is_store) begin
                        pc_write   = 1'b1;
                        retire     = 1'b1;
                        state_next = FETCH;
                    end else begin
                        state_next = WB;
                    end
                end
            end
            WB: begin
                alu_op_c             = dec_op;
                sel_bw_imm_rs2       = uses_imm;
                wr_back_sel          = !is_load;
                regfile_write_enable = (rd != 5'd0);
                pc_write             = 1'b1;
                retire               = 1'b1;
                state_next           = FETCH;
            end
`ifdef MULTICYCLE_CTRL_TIMEOUT_EN
            HALT: begin
                state_next = HALT;
            end
`endif
            default: begin
                state_next = FETCH;
            end
        endcase

        if (timeout_hit) begin
            state_next = HALT;
        end
    end

    // FETCH is the reset state; keep the fetch request low while reset is held.
    assign mem.imem_req      = imem_req_c && rst_n;
    assign mem.dmem_req      = dmem_req_c;
    assign mem.dmem_read_en  = dmem_read_c;
    assign mem.dmem_write_en = dmem_write_c;
    assign alu_op            = ALU_OP_WIDTH'(alu_op_c);
    assign instret           = instret_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: scoreboard bench for multicycle_controller.
// The driver acts as instruction/data memory and pushes the hand-computed
// expected retirement record when it hands over an instruction; the monitor
// pops and compares whenever the DUT strobes pc_write.
module tb_multicycle_controller;

    typedef struct {
        logic [31:0] instr;
        int          delay;
        bit          spur;
        bit          push;
        int          cyc;
        int          memcyc;
        int          alu;
        bit          sel;
        bit          wbsel;
        bit          rfwe;
        bit          ill;
        bit          dwe;
        int          inst;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic [3:0]  alu_op;
    logic        sel_bw_imm_rs2;
    logic        wr_back_sel;
    logic        regfile_write_enable;
    logic        pc_write;
    logic        illegal_instr;
    logic [31:0] instret;
    logic        mem_timeout;

    multicycle_controller_if #(.INSTR_WIDTH(32)) mif ();

    multicycle_controller #(
        .INSTR_WIDTH    (32),
        .ALU_OP_WIDTH   (4),
        .CNT_WIDTH      (32),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .mem                  (mif.master),
        .alu_op               (alu_op),
        .sel_bw_imm_rs2       (sel_bw_imm_rs2),
        .wr_back_sel          (wr_back_sel),
        .regfile_write_enable (regfile_write_enable),
        .pc_write             (pc_write),
        .illegal_instr        (illegal_instr),
        .instret              (instret),
        .mem_timeout          (mem_timeout)
    );

    localparam int NTBL = 15;

    vec_t tbl [NTBL];
    vec_t exp_q [$];
    vec_t mon_e;
    int   checks   = 0;
    int   failures = 0;
    int   idx      = 0;
    int   cur      = 0;
    int   n_active = 14;
    int   dwait    = 0;
    int   mon_cyc  = 0;
    int   mon_mem  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] instr, input int delay, input bit spur,
                                input bit push, input int cyc, input int memcyc, input int alu,
                                input bit sel, input bit wbsel, input bit rfwe, input bit ill,
                                input bit dwe, input int inst);
        vec_t v;
        v.instr = instr; v.delay = delay; v.spur = spur; v.push = push;
        v.cyc = cyc; v.memcyc = memcyc; v.alu = alu; v.sel = sel; v.wbsel = wbsel;
        v.rfwe = rfwe; v.ill = ill; v.dwe = dwe; v.inst = inst;
        return v;
    endfunction

    // Memory model: zero-wait fetch, per-instruction data latency, and
    // optional stray acks while the matching request is low.
    initial begin
        mif.imem_ack   = 1'b0;
        mif.imem_rdata = '0;
        mif.dmem_ack   = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            mif.imem_ack = 1'b0;
            mif.dmem_ack = 1'b0;
            if (mif.imem_req && idx < n_active) begin
                cur            = idx;
                idx            = idx + 1;
                mif.imem_rdata = tbl[cur].instr;
                mif.imem_ack   = 1'b1;
                dwait          = 0;
                if (tbl[cur].push) exp_q.push_back(tbl[cur]);
            end else if (!mif.imem_req && tbl[cur].spur) begin
                mif.imem_rdata = 32'h0000_0063;
                mif.imem_ack   = 1'b1;
            end
            if (mif.dmem_req) begin
                if (dwait >= tbl[cur].delay) mif.dmem_ack = 1'b1;
                else dwait = dwait + 1;
            end else if (tbl[cur].spur) begin
                mif.dmem_ack = 1'b1;
            end
        end
    end

    // Monitor: one record per pc_write strobe.
    always @(negedge clk) begin
        if (!rst_n) begin
            mon_cyc = 0;
            mon_mem = 0;
        end else begin
            mon_cyc = mon_cyc + 1;
            if (mif.dmem_req) mon_mem = mon_mem + 1;
            chk("rfwe_outside_retire", regfile_write_enable & ~pc_write, 0);
            chk("illegal_outside_pcw", illegal_instr & ~pc_write, 0);
            if (pc_write) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_retire", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk($sformatf("cycles_%08h", mon_e.instr), mon_cyc, mon_e.cyc);
                    chk($sformatf("dmem_req_cycles_%08h", mon_e.instr), mon_mem, mon_e.memcyc);
                    chk($sformatf("alu_op_%08h", mon_e.instr), alu_op, mon_e.alu);
                    chk($sformatf("sel_imm_%08h", mon_e.instr), sel_bw_imm_rs2, mon_e.sel);
                    chk($sformatf("wr_back_sel_%08h", mon_e.instr), wr_back_sel, mon_e.wbsel);
                    chk($sformatf("rf_we_%08h", mon_e.instr), regfile_write_enable, mon_e.rfwe);
                    chk($sformatf("illegal_%08h", mon_e.instr), illegal_instr, mon_e.ill);
                    chk($sformatf("dmem_we_%08h", mon_e.instr), mif.dmem_write_en, mon_e.dwe);
                    chk($sformatf("instret_%08h", mon_e.instr), instret, mon_e.inst);
                end
                mon_cyc = 0;
                mon_mem = 0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit hit;
        int cnt;
        //            instr         dly   sp p  cyc mem alu sel wb rf ill dwe inst
        tbl[0]  = mk(32'h002081B3,    0, 1, 1, 4, 0, 0, 0, 1, 1, 0, 0, 0);   // add x3,x1,x2
        tbl[1]  = mk(32'h40335293,    0, 0, 1, 4, 0, 7, 1, 1, 1, 0, 0, 1);   // srai x5,x6,3
        tbl[2]  = mk(32'h40000093,    0, 0, 1, 4, 0, 0, 1, 1, 1, 0, 0, 2);   // addi x1,x0,0x400
        tbl[3]  = mk(32'h0080A203,    3, 0, 1, 8, 4, 0, 1, 0, 1, 0, 0, 3);   // lw x4,8(x1), 3 waits
        tbl[4]  = mk(32'h0020A223,    0, 0, 1, 4, 1, 0, 1, 1, 0, 0, 1, 4);   // sw x2,4(x1)
        tbl[5]  = mk(32'h00000063,    0, 1, 1, 2, 0, 0, 0, 1, 0, 1, 0, 5);   // beq: illegal
        tbl[6]  = mk(32'h00100013,    0, 0, 1, 4, 0, 0, 1, 1, 0, 0, 0, 5);   // addi x0,x0,1
        tbl[7]  = mk(32'h409403B3,    0, 1, 1, 4, 0, 1, 0, 1, 1, 0, 0, 6);   // sub
        tbl[8]  = mk(32'h409453B3,    0, 0, 1, 4, 0, 7, 0, 1, 1, 0, 0, 7);   // sra
        tbl[9]  = mk(32'h029453B3,    0, 0, 1, 4, 0, 6, 0, 1, 1, 0, 0, 8);   // func7=0000001 -> srl
        tbl[10] = mk(32'h009473B3,    0, 0, 1, 4, 0, 9, 0, 1, 1, 0, 0, 9);   // and
        tbl[11] = mk(32'h00543393,    0, 0, 1, 4, 0, 4, 1, 1, 1, 0, 0, 10);  // sltiu
        tbl[12] = mk(32'h0080A203,    0, 0, 1, 5, 1, 0, 1, 0, 1, 0, 0, 11);  // lw, zero wait
        tbl[13] = mk(32'h0080A203,  100, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);   // aborted by reset
        tbl[14] = mk(32'h0080A203, 1000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);   // never acked

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_imem_req", mif.imem_req, 0);
        chk("rst_dmem_req", mif.dmem_req, 0);
        chk("rst_pc_write", pc_write, 0);
        chk("rst_rf_we", regfile_write_enable, 0);
        chk("rst_illegal", illegal_instr, 0);
        chk("rst_alu_op", alu_op, 0);
        chk("rst_sel_imm", sel_bw_imm_rs2, 0);
        chk("rst_wr_back_sel", wr_back_sel, 1);
        chk("rst_instret", instret, 0);
        chk("rst_mem_timeout", mem_timeout, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        hit = 0;
        for (int i = 0; i < 500 && !hit; i++) begin
            @(negedge clk);
            if (idx == 14 && mif.dmem_req) hit = 1;
        end
        chk("abort_point_reached", hit, 1);
        chk("queue_drained", exp_q.size(), 0);
        chk("instret_after_table", instret, 12);

        // Asynchronous reset in the middle of a load's MEM phase.
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_dmem_req", mif.dmem_req, 0);
        chk("abort_dmem_re", mif.dmem_read_en, 0);
        chk("abort_instret", instret, 0);
        chk("abort_imem_req", mif.imem_req, 0);
`ifdef MULTICYCLE_CTRL_TIMEOUT_EN
        n_active = 15;
`endif
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_pc_write", pc_write, 0);
        chk("post_rst_rf_we", regfile_write_enable, 0);
        chk("post_rst_dmem_req", mif.dmem_req, 0);
        chk("post_rst_illegal", illegal_instr, 0);
        chk("post_rst_imem_req", mif.imem_req, 1);

`ifdef MULTICYCLE_CTRL_TIMEOUT_EN
        cnt = 0;
        hit = 0;
        for (int i = 0; i < 80 && !hit; i++) begin
            @(negedge clk);
            if (mem_timeout) hit = 1;
            else if (mif.dmem_req) cnt = cnt + 1;
        end
        chk("timeout_seen", hit, 1);
        chk("timeout_wait_cycles", cnt, 16);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("halt_imem_req", mif.imem_req, 0);
            chk("halt_dmem_req", mif.dmem_req, 0);
            chk("halt_pc_write", pc_write, 0);
            chk("halt_timeout_sticky", mem_timeout, 1);
        end
        #2 rst_n = 1'b0;
        #1;
        chk("timeout_async_clear", mem_timeout, 0);
`else
        cnt = 0;
        hit = 0;
`endif
        chk("scoreboard_empty_end", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Multi-cycle control FSM for the RV32 core; successor to the single-cycle R/I-type decoder.
- Sequences each instruction through FETCH/DECODE/EXECUTE/MEM/WB and handshakes with variable-latency instruction and data memories.
- Adds store support, illegal-opcode detection, x0 write suppression and a retired-instruction counter.
- Drives the existing datapath selects: alu_op, sel_bw_imm_rs2, wr_back_sel, regfile_write_enable, dmem_read_en.

Parameters:
- INSTR_WIDTH, 32, instruction width.
- ALU_OP_WIDTH, 4, ALU operation select width.
- CNT_WIDTH, 32, width of the retired-instruction counter.
- TIMEOUT_CYCLES, 16, memory wait limit; used only with the optional feature.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_rdata  in  INSTR_WIDTH  fetched instruction; valid when imem_ack=1.
- imem_req  out  1  instruction fetch request.
- imem_ack  in  1  fetch complete.
- dmem_req  out  1  data memory request.
- dmem_ack  in  1  data access complete.
- dmem_read_en  out  1  load access.
- dmem_write_en  out  1  store access.
- alu_op  out  ALU_OP_WIDTH  ALU operation.
- sel_bw_imm_rs2  out  1  1 = immediate operand, 0 = rs2.
- wr_back_sel  out  1  0 = memory data, 1 = ALU result.
- regfile_write_enable  out  1  register file write strobe.
- pc_write  out  1  PC <= PC+4 strobe.
- illegal_instr  out  1  one-cycle pulse on an unsupported opcode.
- instret  out  CNT_WIDTH  retired-instruction count.
- mem_timeout  out  1  sticky memory timeout flag.

Behaviour:
- Reset (async, rst_n=0): state=FETCH, IR=0, instret=0, mem_timeout=0. All strobes/requests are 0. alu_op=0 (add), sel_bw_imm_rs2=0, wr_back_sel=1.
- FETCH: imem_req=1. On imem_ack, IR<=imem_rdata, go to DECODE. Ack may arrive in the same cycle as req.
- DECODE (1 cycle):
  - opcode not in {0110011 R, 0010011 I-alu, 0000011 load, 0100011 store}: illegal_instr=1, pc_write=1, go to FETCH. instret does not increment.
  - Otherwise go to EXECUTE.
- EXECUTE (1 cycle): alu_op valid.
  - R/I-alu go to WB; load/store go to MEM.
  - sel_bw_imm_rs2=1 for I-alu, load and store.
- alu_op encoding: add 0, sub 1, sll 2, slt 3, sltu 4, xor 5, srl 6, sra 7, or 8, and 9.
  - R-type: func3/func7 map per RV32I. func7=0100000 selects sub (func3=000) or sra (func3=101). Other func7 values default to add/srl.
  - I-alu: func3=000 is always add (no subi). func3=101 uses func7 for srli/srai.
  - Load/store: add.
  - alu_op is held stable from EXECUTE through the end of WB/MEM.
- MEM: dmem_req=1 and dmem_read_en=1 (load) or dmem_write_en=1 (store), all held until dmem_ack.
  - Load + ack: go to WB.
  - Store + ack: pc_write=1, instret++, go to FETCH.
- WB (1 cycle):
  - regfile_write_enable=1 unless rd (IR[11:7]) = 0.
  - wr_back_sel=0 for load, 1 otherwise.
  - pc_write=1, instret++, go to FETCH.
- Latency with zero-wait memory: R/I-alu 4 cycles, store 4, load 5.
- instret wraps modulo 2^CNT_WIDTH.
- An ack while the matching req is low is ignored.
- Reset mid-instruction aborts immediately. No partial write: no strobe is asserted in the cycle after reset deassertion.

Optional Feature:
- Macro: MULTICYCLE_CTRL_TIMEOUT_EN.
- Defined:
  - A wait counter is cleared on entry to FETCH/MEM and increments each cycle req=1 and ack=0.
  - When it reaches TIMEOUT_CYCLES, set mem_timeout=1 and enter HALT.
  - HALT: all requests and strobes are 0 until reset.
- Undefined: no counter and no HALT state. mem_timeout is tied to 0 and the FSM waits indefinitely.

Decomposition:
- Package ctrl_pkg holds:
  - alu_op_e enum (values above);
  - opcode constants OPC_R, OPC_IALU, OPC_LOAD, OPC_STORE;
  - state_e enum {FETCH, DECODE, EXECUTE, MEM, WB, HALT}.
- Sub-module alu_decoder: combinational opcode/func3/func7 -> alu_op, instantiated once.

Test Plan:
- add x3,x1,x2 (0x002081B3), zero-wait ack -> 4 cycles, alu_op=0, regfile_write_enable=1 in cycle 4 with wr_back_sel=1, instret 0->1.
- srai x5,x6,3 (0x40335293) -> alu_op=7, sel_bw_imm_rs2=1. addi with func7 bits=0100000 -> alu_op=0.
- lw x4,8(x1) with dmem_ack delayed 3 cycles -> dmem_req/dmem_read_en high for 4 cycles, then WB with wr_back_sel=0. Total 8 cycles.
- sw x2,4(x1) -> dmem_write_en=1, regfile_write_enable never asserted, pc_write on the ack cycle.
- Opcode 1100011 (branch) -> illegal_instr pulse in DECODE, pc_write=1, instret unchanged. addi x0,x0,1 -> regfile_write_enable=0, instret++.
- With MULTICYCLE_CTRL_TIMEOUT_EN, TIMEOUT_CYCLES=16, dmem_ack held low -> mem_timeout=1 after 16 wait cycles, FSM in HALT. rst_n=0 clears the flag asynchronously.
